// File: rtl/sisr_bist_ctrl.sv
// ---------------------------------------------------------------------------
// sisr_bist_ctrl
// BIST session controller with a serial-input signature register (SISR).
// Sits downstream of the serial random sequence generator: enables the
// generator for `length` cycles, compacts the serial response into an n-bit
// signature, compares it with a golden value and reports pass/fail.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      begin a session (honoured in IDLE or DONE only)
//   length     number of serial bits to compact, latched on start
//   poly       SISR feedback taps (same encoding as the generator), used live
//   golden     expected signature, sampled in COMPARE
//   Sin        serial response bit
//   gen_en     generator enable, high only while compacting
//   busy       high while compacting or comparing
//   done       session finished, held until the next start
//   pass       signature matched golden, valid while done=1
//   signature  current SISR contents
// ---------------------------------------------------------------------------
module sisr_bist_ctrl #(
  parameter int n  = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] length,
  input  logic [n-1:0]  poly,
  input  logic [n-1:0]  golden,
  input  logic          Sin,
  output logic          gen_en,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [n-1:0]  signature
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t        state;
  logic [n-1:0]  sig;
  logic [CW-1:0] cnt;
  logic [CW-1:0] len_q;

  // One SISR shift: sig[0] is the feedback bit, Sin enters at the top.
  function automatic logic [n-1:0] sisr_next(input logic [n-1:0] s,
                                             input logic          din,
                                             input logic [n-1:0]  taps);
    logic [n-1:0] r;
    logic         fb;
    fb       = s[0];
    r        = '0;
    r[n-1]   = fb ^ din;
    for (int i = 0; i < n - 1; i++) begin
      r[i] = (fb & taps[i]) ^ s[i+1];
    end
    return r;
  endfunction

  // len_q is nonzero whenever RUN is entered, so len_q-1 never underflows;
  // cnt tops out at len_q-1 <= 2^CW-2 before leaving RUN, so it cannot wrap.
  logic last_bit;
  assign last_bit = (cnt == (len_q - 1'b1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sig   <= '0;
      cnt   <= '0;
      len_q <= '0;
      pass  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sig   <= '0;
            cnt   <= '0;
            len_q <= length;
            pass  <= 1'b0;
            state <= (length == '0) ? COMPARE : RUN;
          end
        end
        RUN: begin
          sig <= sisr_next(sig, Sin, poly);
          cnt <= cnt + 1'b1;
          if (last_bit) state <= COMPARE;
        end
        COMPARE: begin
          pass  <= (sig == golden);
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Decoded straight from the state register so an asynchronous reset drops
  // gen_en immediately.
  assign gen_en    = (state == RUN);
  assign busy      = (state == RUN) || (state == COMPARE);
  assign done      = (state == DONE);
  assign signature = sig;

endmodule
